// File: rtl/audio_pkg.sv
// Shared types and constants for the song sequencer: ROM word layout,
// note code classes and the sequencer state set.
package audio_pkg;

  typedef logic [3:0] note_t;

  typedef struct packed {
    logic [3:0] dur;
    note_t      note;
  } song_word_t;

  localparam note_t NOTE_REST_MIN = 4'd10;
  localparam note_t NOTE_END      = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    DONE
  } seq_state_t;

  // A duration field d means d+1 beats.
  function automatic logic [4:0] beats_of(input song_word_t w);
    return {1'b0, w.dur} + 5'd1;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Tempo prescaler: counts clk cycles within a beat, flags the last tick of
// each beat and the start of the articulation gap.
module beat_timer #(
  parameter int unsigned TICKS_PER_BEAT = 25000000,
  parameter int unsigned GAP_CYCLES     = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_beat,
  output logic o_in_gap
);

  localparam int unsigned TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICKS_PER_BEAT - 1);
  // in_gap rises one tick early so a registered gate downstream falls exactly
  // on the first tick of the gap.
  localparam logic [TW-1:0] GAP_START = TW'(TICKS_PER_BEAT - GAP_CYCLES - 1);

  logic [TW-1:0] r_tick;
  logic          r_beat;
  logic          r_in_gap;
  logic [TW-1:0] w_tick_nxt;

  always_comb begin
    w_tick_nxt = (r_tick == LAST) ? '0 : r_tick + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick   <= '0;
      r_beat   <= 1'b0;
      r_in_gap <= 1'b0;
    end else if (i_clear) begin
      r_tick   <= '0;
      r_beat   <= 1'b0;
      r_in_gap <= (GAP_START == '0);
    end else if (i_enable) begin
      r_tick   <= w_tick_nxt;
      r_beat   <= (w_tick_nxt == LAST);
      r_in_gap <= (w_tick_nxt >= GAP_START);
    end
  end

  assign o_beat   = r_beat;
  assign o_in_gap = r_in_gap;

endmodule

// File: rtl/melody_sequencer.sv
// Song player: fetches ROM words, drives note/gate to the note encoder with
// beat timing, handles rests, end-of-song, looping and stop.
module melody_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 25000000,
  parameter int unsigned GAP_CYCLES     = 1250000,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [7:0]        rom_data,
  output logic [3:0]        note,
  output logic              gate,
  output logic              beat,
  output logic              busy,
  output logic              done
);

  import audio_pkg::*;

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd;
  note_t             r_note;
  logic              r_gate;
  logic              r_busy;
  logic              r_done;
  logic [4:0]        r_beats_left;

  song_word_t        w_word;
  logic              w_beat;
  logic              w_in_gap;
  logic              w_tmr_clear;
  logic              w_tmr_enable;

  always_comb begin
    w_word       = song_word_t'(rom_data);
    w_tmr_enable = (r_state == PLAY);
    w_tmr_clear  = (r_state != PLAY) || stop;
  end

  beat_timer #(
    .TICKS_PER_BEAT (TICKS_PER_BEAT),
    .GAP_CYCLES     (GAP_CYCLES)
  ) u_beat_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_enable),
    .o_beat   (w_beat),
    .o_in_gap (w_in_gap)
  );

  // rom_rd is raised on the edge entering FETCH so the ROM word is present
  // during WAIT; this gives the two-cycle fetch overhead per note.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_rd         <= 1'b0;
      r_note       <= '0;
      r_gate       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_beats_left <= '0;
    end else if (stop && (r_state != IDLE)) begin
      r_state      <= IDLE;
      r_rd         <= 1'b0;
      r_gate       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_beats_left <= '0;
    end else begin
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_rd    <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: r_state <= WAIT;
        WAIT: begin
          if (w_word.note < NOTE_REST_MIN) begin
            r_note       <= w_word.note;
            r_gate       <= 1'b1;
            r_beats_left <= beats_of(w_word);
            r_state      <= PLAY;
          end else if (w_word.note != NOTE_END) begin
            r_gate       <= 1'b0;
            r_beats_left <= beats_of(w_word);
            r_state      <= PLAY;
          end else if (loop_en && (r_addr != '0)) begin
            r_addr  <= '0;
            r_rd    <= 1'b1;
            r_state <= FETCH;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        PLAY: begin
          if ((r_beats_left == 5'd1) && w_in_gap) begin
            r_gate <= 1'b0;
          end
          if (w_beat) begin
            r_beats_left <= r_beats_left - 5'd1;
            if (r_beats_left == 5'd1) begin
              r_gate <= 1'b0;
              r_addr <= r_addr + ADDR_W'(1);
              if ((&r_addr) && !loop_en) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= DONE;
              end else begin
                r_rd    <= 1'b1;
                r_state <= FETCH;
              end
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_addr = r_addr;
  assign rom_rd   = r_rd;
  assign note     = r_note;
  assign gate     = r_gate;
  assign beat     = w_beat;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a trace model expands each song into the
// expected per-cycle outputs and every cycle is compared against the DUT.
module tb_melody_sequencer;

  localparam int T  = 8;
  localparam int G  = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, stop, loop_en;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [7:0]    rom_data;
  logic [3:0]    note;
  logic          gate, beat, busy, done;

  logic [7:0] mem [16];

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [3:0] note;
    logic       gate;
    logic       beat;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       idle_exp;
  logic [3:0] model_note;
  int         n_checks = 0;
  int         n_errors = 0;

  melody_sequencer #(
    .TICKS_PER_BEAT (T),
    .GAP_CYCLES     (G),
    .ADDR_W         (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .rom_data (rom_data),
    .note     (note),
    .gate     (gate),
    .beat     (beat),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd) rom_data <= mem[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(bit rd, int addr, logic [3:0] nt, bit g, bit b, bit bs, bit dn);
    obs_t o;
    o.rd = rd; o.addr = 4'(addr); o.note = nt;
    o.gate = g; o.beat = b; o.busy = bs; o.done = dn;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(rom_rd, int'(rom_addr), note, gate, beat, busy, done);
  endfunction

  // Song expansion: FETCH and WAIT cycles per word, then (d+1)*T play cycles.
  task automatic build_trace(input bit lp, input int maxc);
    int addr;
    int code;
    int beats;
    bit fin;
    bit play;
    logic [3:0] cur;
    addr = 0; fin = 0; cur = model_note;
    exp_q.delete();
    while (!fin && exp_q.size() < maxc) begin
      exp_q.push_back(mk(1, addr, cur, 0, 0, 1, 0));
      exp_q.push_back(mk(0, addr, cur, 0, 0, 1, 0));
      code  = int'(mem[addr] & 8'h0F);
      beats = int'(mem[addr] >> 4) + 1;
      if (code == 15) begin
        if (lp && addr != 0) addr = 0;
        else begin
          exp_q.push_back(mk(0, addr, cur, 0, 0, 0, 1));
          fin = 1;
        end
      end else begin
        play = (code < 10);
        if (play) cur = 4'(code);
        for (int i = 0; i < beats * T; i++)
          exp_q.push_back(mk(0, addr, cur,
                             play && !((i / T) == beats - 1 && (i % T) >= T - G),
                             (i % T) == T - 1, 1, 0));
        addr = (addr + 1) % 16;
        if (addr == 0 && !lp) begin
          exp_q.push_back(mk(0, 0, cur, 0, 0, 0, 1));
          fin = 1;
        end
      end
    end
  endtask

  task automatic run_song(input bit lp, input int maxc, input int stop_at, input bit rnd_start,
                          input bit use_reset, output int n_gate, output int n_beat,
                          output int done_cyc);
    int   last;
    obs_t o;
    obs_t lastexp;
    build_trace(lp, maxc);
    loop_en = lp; n_gate = 0; n_beat = 0; done_cyc = 0;
    last = (stop_at > 0 && stop_at < exp_q.size()) ? stop_at : exp_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= last; k++) begin
      o = sample();
      check($sformatf("trace_c%0d", k), {17'b0, o}, {17'b0, exp_q[k-1]});
      if (o.gate) n_gate++;
      if (o.beat) n_beat++;
      if (o.done && done_cyc == 0) done_cyc = k;
      start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == last && !exp_q[k-1].done) begin
        if (use_reset) reset = 1'b1;
        else stop = 1'b1;
      end
      @(negedge clk);
    end
    lastexp = exp_q[last-1];
    if (reset) begin
      model_note = '0;
      idle_exp   = '0;
    end else begin
      model_note = lastexp.note;
      idle_exp   = mk(0, int'(lastexp.addr), lastexp.note, 0, 0, 0, 0);
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check(reset ? "reset_idle" : "idle_after", {17'b0, sample()}, {17'b0, idle_exp});
      @(negedge clk);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  initial begin
    int g, b, d, stop_at;
    bit lp, rst;
    reset = 1'b1; start = 1'b1; stop = 1'b0; loop_en = 1'b0;
    model_note = '0; idle_exp = '0;
    fill(8'h0F);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_vals", {17'b0, sample()}, 32'h0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_start_ignored", {17'b0, sample()}, 32'h0);

    mem[0] = 8'h15; mem[1] = 8'h0F;
    run_song(0, 1000, 0, 0, 0, g, b, d);
    check("t2_gate_cycles", g, 14);
    check("t2_beats", b, 2);
    check("t2_done_cycle", d, 21);

    fill(8'h0F); mem[0] = 8'h0C; mem[1] = 8'h03;
    run_song(0, 1000, 0, 0, 0, g, b, d);
    check("t3_gate_cycles", g, 6);
    check("t3_done_cycle", d, 23);

    fill(8'h0F); mem[0] = 8'h01;
    run_song(1, 1000, 30, 1, 0, g, b, d);
    check("t4_loop_no_done", d, 0);
    fill(8'h0F);
    run_song(1, 1000, 0, 0, 0, g, b, d);
    check("t4_end_at_0_done", d, 3);

    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stop_start_idle", {17'b0, sample()}, {17'b0, idle_exp});
    end
    start = 1'b0; stop = 1'b0;
    @(negedge clk);

    fill(8'h00); mem[0] = 8'h17;
    run_song(0, 1000, 25, 1, 1, g, b, d);
    check("reset_mid_no_done", d, 0);

    fill(8'h00);
    run_song(0, 1000, 0, 1, 0, g, b, d);
    check("t6_gate_cycles", g, 96);
    check("t6_beats", b, 16);
    check("t6_done_cycle", d, 161);
    run_song(1, 1000, 400, 1, 0, g, b, d);
    check("t6_loop_no_done", d, 0);

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = {4'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 14))};
      lp      = 1'($urandom_range(0, 1));
      stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 150)) : 0;
      if (lp && stop_at == 0) stop_at = 300;
      rst = (stop_at != 0) && ($urandom_range(0, 4) == 0);
      run_song(lp, 1000, stop_at, 1'($urandom_range(0, 1)), rst, g, b, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Plays a song stored in an external ROM. Each ROM word holds a note code and a duration. The block fetches one word at a time and drives the note index into the audio note encoder. It gates the tone with per-beat timing taken from a tempo prescaler, and supports rests, end-of-song, looping and stop.

Parameters:
TICKS_PER_BEAT, 25000000, clk cycles per beat (120 BPM at 50 MHz); must be >= 2
GAP_CYCLES, 1250000, articulation gap: gate low for the last GAP_CYCLES cycles of each note; 0 <= GAP_CYCLES < TICKS_PER_BEAT
ADDR_W, 8, song ROM address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level sampled each cycle; begins playback from address 0 when idle
stop  in  1  abort playback; has priority over start
loop_en  in  1  on end-of-song, restart at address 0 instead of finishing
rom_addr  out  ADDR_W  song ROM address
rom_rd  out  1  ROM read strobe; data valid on the following cycle
rom_data  in  8  song word: [7:4] dur, [3:0] note code
note  out  4  note index to the note encoder
gate  out  1  1 = tone audible
beat  out  1  one-cycle pulse at each beat boundary while playing
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  one-cycle pulse on natural end of song

Behaviour:
- All outputs are registered. Reset values: rom_addr=0, rom_rd=0, note=0, gate=0, beat=0, busy=0, done=0; state IDLE; counters 0.
- Note codes: 0-9 are playable; 10-14 are rests; 15 is END. A duration field d means d+1 beats.
- IDLE: start=1 and stop=0 -> rom_addr<=0, busy<=1, go to FETCH. Start is ignored in every other state.
- FETCH (1 cycle): rom_rd=1 at the current rom_addr -> WAIT.
- WAIT (1 cycle): capture rom_data and decode it:
  - Playable: note<=code, gate<=1, beats_left<=d+1, beat counter cleared -> PLAY.
  - Rest: note holds, gate<=0, beats_left<=d+1 -> PLAY.
  - END, with loop_en=1 and rom_addr!=0: rom_addr<=0 -> FETCH.
  - END otherwise (includes END at address 0, which prevents an infinite zero-length loop): -> DONE.
- Start latency: start sampled at edge N gives rom_rd high in cycle N+1; gate/note valid from cycle N+3.
- PLAY:
  - The tick counter counts 0..TICKS_PER_BEAT-1. At the terminal count, beat pulses for one cycle and beats_left decrements.
  - For a playable note, gate drops to 0 when beats_left==1 and tick >= TICKS_PER_BEAT-GAP_CYCLES.
  - When beats_left reaches 0, rom_addr increments -> FETCH.
  - If rom_addr was all-ones (wrap to 0): loop_en=1 -> FETCH at 0; loop_en=0 -> DONE.
- Per-note period: (d+1)*TICKS_PER_BEAT + 2 cycles. gate is 0 during FETCH and WAIT.
- DONE (1 cycle): done=1, gate=0, busy<=0 -> IDLE.
- stop=1 in any non-IDLE state: next cycle IDLE, gate=0, busy=0, rom_rd=0, beat=0, no done pulse. note keeps its last value.
- stop and start in the same IDLE cycle: remain IDLE.
- reset mid-operation: all state and outputs return to reset values on the next edge.
- loop_en is sampled only at the END/wrap decision.

Decomposition:
- Package audio_pkg:
  - note_t (logic [3:0])
  - song_word_t, a packed struct {dur[3:0], note[3:0]}
  - constants NOTE_REST_MIN=10 and NOTE_END=15
  - seq_state_t enum {IDLE, FETCH, WAIT, PLAY, DONE}
- Sub-module beat_timer, parameterised by TICKS_PER_BEAT and GAP_CYCLES:
  - inputs: clear, enable
  - outputs: beat pulse, in_gap flag
- The FSM, address register and beats_left counter stay in melody_sequencer.

Test Plan:
Bench parameters: TICKS_PER_BEAT=8, GAP_CYCLES=2, ADDR_W=4.
1. Assert reset for 2 cycles -> all outputs 0, state IDLE; start pulsed while reset is high is ignored.
2. ROM[0]=0x15, ROM[1]=0x0F, start pulse -> rom_rd at cycles 1 and 19. note=5 from cycle 3; gate high 14 cycles then low; 2 beat pulses. Then done=1 for one cycle, busy falls with it.
3. ROM[0]=0x0C (rest), ROM[1]=0x03, ROM[2]=0x0F -> gate low through 8 PLAY cycles. Then note=3, gate high 6 cycles, then done.
4. loop_en=1, ROM[0]=0x01, ROM[1]=0x0F -> note 1 repeats every 10 cycles with no done. stop mid-note -> next cycle gate=0, busy=0, no done. Separately, ROM[0]=0x0F with loop_en=1 -> done after 3 cycles.
5. start while busy -> no restart, rom_addr unaffected. stop and start together in IDLE -> stays IDLE. reset mid-PLAY -> reset values next cycle.
6. All 16 words=0x00, loop_en=0 -> 16 notes of 10 cycles each, address wraps, then done. With loop_en=1 -> continuous playback, no done.
